// File: rtl/wb_queue_if.sv
// Writeback queue bus: producer requests, register file write port, and decode-side lookups.
// The producer/regfile side uses the master modport; the queue uses the slave modport.
interface wb_queue_if #(
   parameter int DEPTH = 4,
   parameter int DW    = 16,
   parameter int AW    = 3
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             mem_vld;
   logic [AW-1:0]    mem_dest;
   logic [DW-1:0]    mem_data;
   logic             alu_vld;
   logic [AW-1:0]    alu_dest;
   logic [DW-1:0]    alu_data;
   logic             q_rdy;
   logic             wr;
   logic [AW-1:0]    dest_out;
   logic [DW-1:0]    data_out;
   logic             wr_success;
   logic [AW-1:0]    fwd_reg;
   logic             fwd_hit;
   logic [DW-1:0]    fwd_data;
   logic [(1<<AW)-1:0] pend;
   logic [CW-1:0]    count;
   logic             err;

   modport master (
      output mem_vld, mem_dest, mem_data, alu_vld, alu_dest, alu_data,
             wr_success, fwd_reg,
      input  q_rdy, wr, dest_out, data_out, fwd_hit, fwd_data, pend, count, err
   );

   modport slave (
      input  mem_vld, mem_dest, mem_data, alu_vld, alu_dest, alu_data,
             wr_success, fwd_reg,
      output q_rdy, wr, dest_out, data_out, fwd_hit, fwd_data, pend, count, err
   );
endinterface

// File: rtl/wb_queue.sv
// In-order writeback queue: up to two enqueues (MEM then EX) and one register file write per cycle,
// with a per-GPR pending scoreboard and youngest-entry forwarding lookup.
module wb_queue #(
   parameter int DEPTH = 4,
   parameter int DW    = 16,
   parameter int AW    = 3
) (
   input logic        clk,
   input logic        rst,
   wb_queue_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int NR = 1 << AW;

   logic [DEPTH-1:0]  ent_vld;
   logic [AW-1:0]     ent_dest [DEPTH];
   logic [DW-1:0]     ent_data [DEPTH];
   logic [PW-1:0]     head;
   logic [PW-1:0]     tail;
   logic [CW-1:0]     count;
   logic              wr_d;
   logic              err;

   logic              enq_req;
   logic              accept;
   logic [CW-1:0]     enq_n;
   logic [PW-1:0]     alu_slot;
   logic [PW-1:0]     scan_idx;
   logic [NR-1:0]     pend;
   logic              fwd_hit;
   logic [DW-1:0]     fwd_data;

   assign bus.count    = count;
   assign bus.err      = err;
   assign bus.q_rdy    = (CW'(DEPTH) - count) >= CW'(2);
   assign bus.wr       = (count != '0);
   assign bus.dest_out = bus.wr ? ent_dest[head] : '0;
   assign bus.data_out = bus.wr ? ent_data[head] : '0;
   assign bus.pend     = pend;
   assign bus.fwd_hit  = fwd_hit;
   assign bus.fwd_data = fwd_data;

   assign enq_req  = bus.mem_vld | bus.alu_vld;
   assign accept   = enq_req & bus.q_rdy;
   assign enq_n    = accept ? (CW'(bus.mem_vld) + CW'(bus.alu_vld)) : '0;
   assign alu_slot = tail + PW'(bus.mem_vld);

   // Scan oldest to youngest so the last match left standing is the youngest entry.
   always_comb begin
      pend     = '0;
      fwd_hit  = 1'b0;
      fwd_data = '0;
      scan_idx = '0;
      for (int k = 0; k < DEPTH; k++) begin
         scan_idx = head + PW'(k);
         if (ent_vld[scan_idx]) begin
            pend[ent_dest[scan_idx]] = 1'b1;
            if (ent_dest[scan_idx] == bus.fwd_reg) begin
               fwd_hit  = 1'b1;
               fwd_data = ent_data[scan_idx];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent_vld <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_dest[i] <= '0;
            ent_data[i] <= '0;
         end
         head  <= '0;
         tail  <= '0;
         count <= '0;
         wr_d  <= 1'b0;
         err   <= 1'b0;
      end else begin
         wr_d <= bus.wr;
         if ((bus.wr_success != wr_d) || (enq_req && !bus.q_rdy))
            err <= 1'b1;

         if (bus.wr) begin
            ent_vld[head] <= 1'b0;
            head          <= head + PW'(1);
         end

         // q_rdy guarantees two free slots, so the tail slots never alias the head being popped.
         if (accept) begin
            if (bus.mem_vld) begin
               ent_vld[tail]  <= 1'b1;
               ent_dest[tail] <= bus.mem_dest;
               ent_data[tail] <= bus.mem_data;
            end
            if (bus.alu_vld) begin
               ent_vld[alu_slot]  <= 1'b1;
               ent_dest[alu_slot] <= bus.alu_dest;
               ent_data[alu_slot] <= bus.alu_data;
            end
            tail <= tail + enq_n[PW-1:0];
         end

         count <= count + enq_n - CW'(bus.wr);
      end
   end
endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: queue-based reference model compared every cycle, plus literal spot checks.
module tb_wb_queue;
   localparam int DEPTH = 4;
   localparam int DW    = 16;
   localparam int AW    = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   wb_queue_if #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) bus ();
   wb_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [AW-1:0] dest;
      logic [DW-1:0] data;
   } ent_t;

   ent_t          mq[$];
   logic          m_err = 1'b0;
   logic          m_wrd = 1'b0;
   logic          m_had;
   logic          m_rdy;
   logic          ack_en = 1'b1;
   logic          wr_last = 1'b0;
   logic [DW-1:0] dut_log[$];

   logic [7:0]    e_pend;
   logic          e_hit;
   logic [DW-1:0] e_fdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain FIFO of {dest,data}, updated on the clock edge.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_err = 1'b0;
         m_wrd = 1'b0;
      end else begin
         m_had = (mq.size() != 0);
         m_rdy = ((DEPTH - mq.size()) >= 2);
         if (bus.wr_success !== m_wrd) m_err = 1'b1;
         m_wrd = m_had;
         if (m_had) void'(mq.pop_front());
         if ((bus.mem_vld || bus.alu_vld) && !m_rdy) m_err = 1'b1;
         else begin
            if (bus.mem_vld) mq.push_back('{bus.mem_dest, bus.mem_data});
            if (bus.alu_vld) mq.push_back('{bus.alu_dest, bus.alu_data});
         end
      end
   end

   // Register file stand-in: acknowledges one cycle after each wr.
   always @(negedge clk) wr_last = bus.wr;
   always @(posedge clk) begin
      #1;
      bus.wr_success = ack_en && wr_last && !rst;
   end

   always @(negedge clk) begin
      e_pend  = '0;
      e_hit   = 1'b0;
      e_fdata = '0;
      for (int i = 0; i < mq.size(); i++) begin
         e_pend[mq[i].dest] = 1'b1;
         if (mq[i].dest == bus.fwd_reg) begin
            e_hit   = 1'b1;
            e_fdata = mq[i].data;
         end
      end
      chk("wr",       32'(bus.wr),       32'(mq.size() != 0));
      chk("dest_out", 32'(bus.dest_out), (mq.size() != 0) ? 32'(mq[0].dest) : 32'd0);
      chk("data_out", 32'(bus.data_out), (mq.size() != 0) ? 32'(mq[0].data) : 32'd0);
      chk("count",    32'(bus.count),    32'(mq.size()));
      chk("q_rdy",    32'(bus.q_rdy),    32'((DEPTH - mq.size()) >= 2));
      chk("pend",     32'(bus.pend),     32'(e_pend));
      chk("fwd_hit",  32'(bus.fwd_hit),  32'(e_hit));
      chk("fwd_data", 32'(bus.fwd_data), 32'(e_fdata));
      chk("err",      32'(bus.err),      32'(m_err));
      if (bus.wr) dut_log.push_back(bus.data_out);
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic mv, input logic [AW-1:0] md, input logic [DW-1:0] mdat,
                        input logic av, input logic [AW-1:0] ad, input logic [DW-1:0] adat);
      bus.mem_vld  = mv;
      bus.mem_dest = md;
      bus.mem_data = mdat;
      bus.alu_vld  = av;
      bus.alu_dest = ad;
      bus.alu_data = adat;
      step();
      bus.mem_vld = 1'b0;
      bus.alu_vld = 1'b0;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      bus.mem_vld    = 1'b0;
      bus.mem_dest   = '0;
      bus.mem_data   = '0;
      bus.alu_vld    = 1'b0;
      bus.alu_dest   = '0;
      bus.alu_data   = '0;
      bus.fwd_reg    = '0;
      bus.wr_success = 1'b0;
      #1 rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      #1;

      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_wr",    32'(bus.wr),    32'd0);
      chk("rst_err",   32'(bus.err),   32'd0);
      chk("rst_q_rdy", 32'(bus.q_rdy), 32'd1);
      chk("rst_pend",  32'(bus.pend),  32'd0);

      // Single EX write to R3
      bus.fwd_reg = 3'd3;
      drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 16'h1234);
      chk("t1_wr",       32'(bus.wr),       32'd1);
      chk("t1_dest",     32'(bus.dest_out), 32'd3);
      chk("t1_data",     32'(bus.data_out), 32'h1234);
      chk("t1_pend",     32'(bus.pend),     32'h08);
      chk("t1_fwd_data", 32'(bus.fwd_data), 32'h1234);
      step();
      chk("t1_wr_done",  32'(bus.wr),       32'd0);
      chk("t1_pend_clr", 32'(bus.pend),     32'd0);
      step();
      chk("t1_err",      32'(bus.err),      32'd0);

      // Same-cycle MEM and EX writes to R2: forwarding sees the younger one
      bus.fwd_reg = 3'd2;
      drive(1'b1, 3'd2, 16'hAAAA, 1'b1, 3'd2, 16'h5555);
      chk("t2_data0",    32'(bus.data_out), 32'hAAAA);
      chk("t2_fwd_hit",  32'(bus.fwd_hit),  32'd1);
      chk("t2_fwd_data", 32'(bus.fwd_data), 32'h5555);
      chk("t2_pend0",    32'(bus.pend),     32'h04);
      chk("t2_count",    32'(bus.count),    32'd2);
      step();
      chk("t2_data1",    32'(bus.data_out), 32'h5555);
      chk("t2_pend1",    32'(bus.pend),     32'h04);
      step();
      chk("t2_wr_done",  32'(bus.wr),       32'd0);
      chk("t2_pend_clr", 32'(bus.pend),     32'd0);

      // Fill until q_rdy drops, then a dropped EX request
      dut_log.delete();
      bus.fwd_reg = 3'd7;
      drive(1'b1, 3'd1, 16'h3000, 1'b1, 3'd4, 16'h3001);
      chk("t3_count2",   32'(bus.count),    32'd2);
      chk("t3_rdy2",     32'(bus.q_rdy),    32'd1);
      drive(1'b1, 3'd5, 16'h3002, 1'b1, 3'd6, 16'h3003);
      chk("t3_count3",   32'(bus.count),    32'd3);
      chk("t3_rdy3",     32'(bus.q_rdy),    32'd0);
      chk("t3_err0",     32'(bus.err),      32'd0);
      drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 16'hDEAD);
      chk("t4_err",      32'(bus.err),      32'd1);
      chk("t4_count",    32'(bus.count),    32'd2);
      chk("t4_rdy",      32'(bus.q_rdy),    32'd1);
      repeat (4) step();
      chk("t4_empty",    32'(bus.count),    32'd0);
      chk("t4_err_hold", 32'(bus.err),      32'd1);
      chk("t4_log_len",  32'(dut_log.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         chk("t4_log", (i < dut_log.size()) ? 32'(dut_log[i]) : 32'hFFFF_FFFF, 32'h3000 + 32'(i));
      pulse_rst();
      chk("t4_err_rst",  32'(bus.err),      32'd0);

      // Missing acknowledge
      ack_en = 1'b0;
      drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 16'h0077);
      chk("t5_wr",       32'(bus.wr),       32'd1);
      chk("t5_err0",     32'(bus.err),      32'd0);
      step();
      chk("t5_err1",     32'(bus.err),      32'd0);
      step();
      chk("t5_err2",     32'(bus.err),      32'd1);
      ack_en = 1'b1;
      pulse_rst();

      // Asynchronous reset mid-drain
      bus.fwd_reg = 3'd1;
      drive(1'b1, 3'd1, 16'h6001, 1'b1, 3'd2, 16'h6002);
      drive(1'b1, 3'd3, 16'h6003, 1'b1, 3'd4, 16'h6004);
      chk("t6_count3",   32'(bus.count),    32'd3);
      #1 rst = 1'b1;
      #1;
      chk("t6_wr",       32'(bus.wr),       32'd0);
      chk("t6_count",    32'(bus.count),    32'd0);
      chk("t6_pend",     32'(bus.pend),     32'd0);
      chk("t6_fwd_hit",  32'(bus.fwd_hit),  32'd0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t6_idle_wr", 32'(bus.wr), 32'd0);
      end
      drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 16'h0666);
      chk("t6_new_wr",   32'(bus.wr),       32'd1);
      chk("t6_new_data", 32'(bus.data_out), 32'h0666);
      repeat (3) step();
      chk("t6_err",      32'(bus.err),      32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
